sd_serializer: RTL
==================

SD_SERIALIZER -- requirements
Module: sd_serializer

Interface
REQ-001 SHALL have ports, clock and reset first: sclk input 1 (serial bit clock); rst input 1 (reset, synchronous, active-high).
REQ-002 SHALL have input frame32, 1 bit: 1 = 32-bit frame, 0 = 16-bit frame.
REQ-003 SHALL have input std_i2s, 1 bit: 1 = Philips I2S (one-bit delay), 0 = MSB-justified.
REQ-004 SHALL have inputs tx_ren and del_tx_ren, 1 bit each: channel-active read enables, undelayed and one-bit-delayed.
REQ-005 SHALL have inputs fifo_data, 32 bits (show-ahead Tx FIFO head), and fifo_empty, 1 bit.
REQ-006 SHALL have output fifo_rd, 1 bit: one-cycle pop strobe to the Tx FIFO.
REQ-007 SHALL have output sd, 1 bit: serial data line.
REQ-008 SHALL have output busy, 1 bit: word shift in progress.
REQ-009 SHALL have output underrun, 1 bit (sticky), and input clr_underrun, 1 bit (clears it).

Function
REQ-010 SHALL update all state on the falling edge of sclk; fifo_rd SHALL be combinational from registered state and inputs.
REQ-011 SHALL derive en = std_i2s ? del_tx_ren : tx_ren.
REQ-012 SHALL implement FSM states IDLE and SHIFT.
REQ-013 IDLE->SHIFT when en=1: same edge loads shreg, clears bitcnt to 0, latches frame32 into len32; fifo_rd=1 during that cycle.
REQ-014 SHALL load shreg as fifo_data[31:0] when frame32=1, and as {fifo_data[15:0], 16'h0} when frame32=0.
REQ-015 SHALL drive sd = shreg[31] while in SHIFT, else 0; MSB appears on sd one sclk after the load edge.
REQ-016 In SHIFT with en=1, each edge SHALL shift shreg left by 1 and increment bitcnt (5 bits).
REQ-017 At the last bit (bitcnt = 31 if len32, 15 otherwise) with en=1: SHALL reload from the FIFO (fifo_rd=1), bitcnt wraps to 0; back-to-back words, no gap bit.
REQ-018 At the last bit with en=0: SHALL go to IDLE with no pop.
REQ-019 If en drops mid-word: SHALL go to IDLE next edge, discard the remaining bits, set sd=0, clear bitcnt, and not pop.
REQ-020 On load with fifo_empty=1: SHALL force fifo_rd=0, load shreg = 0, and set underrun.
REQ-021 If clr_underrun and a new underrun occur in the same cycle, set SHALL win.
REQ-022 frame32 changes mid-word SHALL take effect only at the next load.
REQ-023 busy SHALL equal (state == SHIFT).

Reset
REQ-024 rst=1 at a falling edge SHALL force: state IDLE, shreg 0, bitcnt 0, len32 0, underrun 0.
REQ-025 While rst=1, SHALL drive sd=0, busy=0, fifo_rd=0.
REQ-026 Reset asserted mid-word SHALL discard the word with no pop in that cycle; operation resumes per REQ-013 after release.

Configuration
REQ-027 Macro SD_SER_UNDERRUN_EN defined: underrun detection per REQ-020/021 is included.
REQ-028 Macro undefined: underrun is tied to 0 and clr_underrun is ignored; an empty load still sends zeros and does not pop.

Structure
REQ-029 ws_state_t, the frame-size enum, the standard enum, and constants FRAME16_LAST=15 and FRAME32_LAST=31 SHALL reside in ctrl_pkg.
REQ-030 One sub-module, sd_frame_counter, SHALL own bitcnt, len32, and the last-bit flag; the FSM and shift register stay in sd_serializer.

Verification
REQ-031 Case 1: frame32=1, std_i2s=0, tx_ren held high for 64 cycles, FIFO holds A5A5_0F0F then 8000_0001 -> sd reproduces both words MSB-first, back-to-back; exactly 2 fifo_rd pulses, 32 cycles apart.
REQ-032 Case 2: frame32=0, std_i2s=1, del_tx_ren high 16 cycles, head 0000_C3A1 -> sd = C3A1 MSB-first starting one sclk after load; 1 pop; then IDLE, sd=0.
REQ-033 Case 3: fifo_empty=1 at load -> 32 zero bits on sd, fifo_rd never asserted, underrun=1 until clr_underrun pulse (SD_SER_UNDERRUN_EN defined); underrun stays 0 when the macro is undefined.
REQ-034 Case 4: en dropped at bitcnt=10 -> IDLE on next edge, sd=0, no pop; next en rise loads a fresh word with bitcnt=0.
REQ-035 Case 5: rst pulsed at bitcnt=20 -> next cycle sd=0, busy=0, underrun=0; no fifo_rd during reset.
REQ-036 Case 6: frame32 toggled 1->0 at bitcnt=5 -> current word finishes 32 bits; next word is 16 bits.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the serial-data transmit path.
// Used by sd_serializer and sd_frame_counter.
package ctrl_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned HALF_W   = 16;
  localparam int unsigned BITCNT_W = 5;

  localparam logic [BITCNT_W-1:0] FRAME16_LAST = BITCNT_W'(15);
  localparam logic [BITCNT_W-1:0] FRAME32_LAST = BITCNT_W'(31);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ws_state_t;

  typedef enum logic {
    FRAME_16 = 1'b0,
    FRAME_32 = 1'b1
  } frame_size_t;

  typedef enum logic {
    STD_MSB_JUST = 1'b0,
    STD_PHILIPS  = 1'b1
  } i2s_std_t;

  // 16-bit frames are left-aligned so the shift-out path is always from bit 31.
  function automatic logic [WORD_W-1:0] frame_word(input logic [WORD_W-1:0] data,
                                                   input frame_size_t       fs);
    return (fs == FRAME_32) ? data : {data[HALF_W-1:0], HALF_W'(0)};
  endfunction

endpackage

// File: rtl/sd_frame_counter.sv
// Bit counter for the serializer: tracks position within the word, the
// latched word length, and flags the last bit. State updates on falling sclk.
module sd_frame_counter (
  input  logic sclk,
  input  logic rst,
  input  logic load,
  input  logic adv,
  input  logic clr,
  input  logic frame32,
  output logic last_c
);
  import ctrl_pkg::*;

  logic [BITCNT_W-1:0] bitcnt;
  logic                len32;

  // Load restarts the count and captures the new word length.
  always_ff @(negedge sclk) begin
    if (rst) begin
      bitcnt <= '0;
      len32  <= 1'b0;
    end else if (load) begin
      bitcnt <= '0;
      len32  <= frame32;
    end else if (clr) begin
      bitcnt <= '0;
    end else if (adv) begin
      bitcnt <= bitcnt + BITCNT_W'(1);
    end
  end

  assign last_c = (bitcnt == (len32 ? FRAME32_LAST : FRAME16_LAST));

endmodule

// File: rtl/sd_serializer.sv
// I2S / MSB-justified serial data transmitter fed from a show-ahead Tx FIFO.
// Define SD_SER_UNDERRUN_EN to include sticky underrun detection.
module sd_serializer
  import ctrl_pkg::*;
(
  input  logic        sclk,
  input  logic        rst,
  input  logic        frame32,
  input  logic        std_i2s,
  input  logic        tx_ren,
  input  logic        del_tx_ren,
  input  logic [31:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  output logic        sd,
  output logic        busy,
  output logic        underrun,
  input  logic        clr_underrun
);

  ws_state_t         state, state_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic              en_c;
  logic              load_c;
  logic              adv_c;
  logic              clr_c;
  logic              last_c;

  assign en_c = (i2s_std_t'(std_i2s) == STD_PHILIPS) ? del_tx_ren : tx_ren;

  sd_frame_counter u_cnt (
    .sclk    (sclk),
    .rst     (rst),
    .load    (load_c),
    .adv     (adv_c),
    .clr     (clr_c),
    .frame32 (frame32),
    .last_c  (last_c)
  );

  always_ff @(negedge sclk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
    end
  end

  // Last bit with enable still high reloads directly, giving back-to-back words.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    load_c    = 1'b0;
    adv_c     = 1'b0;
    clr_c     = 1'b0;
    case (state)
      IDLE: begin
        if (en_c) begin
          load_c    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!en_c) begin
          clr_c     = 1'b1;
          state_nxt = IDLE;
        end else if (last_c) begin
          load_c = 1'b1;
        end else begin
          adv_c     = 1'b1;
          shreg_nxt = {shreg[WORD_W-2:0], 1'b0};
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load_c) begin
      shreg_nxt = fifo_empty ? '0 : frame_word(fifo_data, frame_size_t'(frame32));
    end
  end

  assign fifo_rd = load_c & ~fifo_empty & ~rst;
  assign busy    = (state == SHIFT) & ~rst;
  assign sd      = busy & shreg[WORD_W-1];

`ifdef SD_SER_UNDERRUN_EN
  // A fresh underrun wins over a simultaneous clear.
  always_ff @(negedge sclk) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if (load_c && fifo_empty) begin
      underrun <= 1'b1;
    end else if (clr_underrun) begin
      underrun <= 1'b0;
    end
  end
`else
  logic unused_clr_underrun;
  assign unused_clr_underrun = clr_underrun;
  assign underrun = 1'b0;
`endif

endmodule
